// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: keeps the PC, issues one 4-byte fetch at a time to
// the memory controller and queues each returned word with its PC in a
// circular buffer that the decoder drains. A redirect flushes everything and
// restarts fetch at the new target.
module if_fetch_queue #(
  parameter int          IQ_DEPTH    = 16,
  parameter int          IQ_ADDR_LEN = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [IQ_ADDR_LEN:0]   FULL_CNT = (IQ_ADDR_LEN+1)'(IQ_DEPTH);
  localparam logic [IQ_ADDR_LEN:0]   CNT_ONE  = (IQ_ADDR_LEN+1)'(1);
  localparam logic [IQ_ADDR_LEN-1:0] PTR_ONE  = IQ_ADDR_LEN'(1);

  logic [1:0]             state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            addr_q, addr_d;
  logic                   req_q, req_d;
  logic [IQ_ADDR_LEN-1:0] head_q, head_d;
  logic [IQ_ADDR_LEN-1:0] tail_q, tail_d;
  logic [IQ_ADDR_LEN:0]   count_q, count_d;

  // Queue storage is data only; it is never reset, so its head is gated by
  // inst_valid on the way out.
  logic [31:0] iq_inst_q [IQ_DEPTH];
  logic [31:0] iq_pc_q   [IQ_DEPTH];

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count_q != '0);

  // Next-state logic: redirect overrides everything, otherwise run the fetch FSM and queue bookkeeping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (jump_flag) begin
      // Any done or pop in this cycle belongs to the abandoned stream.
      pc_d    = jump_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      req_d   = 1'b0;
      state_d = S_DROP;
    end else begin
      pop = not_empty && inst_ready;

      case (state_q)
        S_IDLE: begin
          // Only issue when a slot is guaranteed for the returning word.
          if (count_q < FULL_CNT) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (if_load_done) begin
            push    = 1'b1;
            tail_d  = tail_q + PTR_ONE;
            pc_d    = pc_q + 32'd4;
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          // A done seen here answers the pre-redirect address; discard it.
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (pop) begin
        head_d = head_q + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: synchronous active-low reset, frozen while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue write port: store the returned word and its PC at the tail
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && push) begin
      iq_inst_q[tail_q] <= mem_ctrl_instru_to_if;
      iq_pc_q[tail_q]   <= pc_q;
    end
  end

  assign if_read_or_not = req_q;
  assign intru_addr     = addr_q;
  assign inst_valid     = not_empty;
  assign inst_out       = not_empty ? iq_inst_q[head_q] : 32'h0;
  assign inst_pc        = not_empty ? iq_pc_q[head_q]   : 32'h0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a simple memory-controller model answers
// fetches with word = addr + 0x100 after a programmable latency, and a linear
// sequence of steps exercises fill, pop/refill, redirects, miss latency,
// rdy_in freeze and mid-fetch reset.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_data;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  bit mem_en  = 1'b0;
  int mem_lat = 1;
  int mem_cnt = 0;

  if_fetch_queue #(
    .IQ_DEPTH   (16),
    .IQ_ADDR_LEN(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_in               (clk),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .if_read_or_not       (if_read_or_not),
    .intru_addr           (intru_addr),
    .if_load_done         (if_load_done),
    .mem_ctrl_instru_to_if(mem_data),
    .jump_flag            (jump_flag),
    .jump_addr            (jump_addr),
    .inst_valid           (inst_valid),
    .inst_out             (inst_out),
    .inst_pc              (inst_pc),
    .inst_ready           (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory-controller model: after the request has been visible for
  // mem_lat cycles, pulse done for one cycle with word = addr + 0x100.
  task automatic mem_update();
    if_load_done = 1'b0;
    if (if_read_or_not && rdy_in) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        if_load_done = 1'b1;
        mem_data     = intru_addr + 32'h100;
        mem_cnt      = 0;
      end
    end else if (!if_read_or_not) begin
      mem_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mem_en) mem_update();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, if_read_or_not}, 32'h0);
    chk({tag, "_addr"},  intru_addr,               32'h0);
    chk({tag, "_valid"}, {31'b0, inst_valid},     32'h0);
    chk({tag, "_out"},   inst_out,                 32'h0);
    chk({tag, "_pc"},    inst_pc,                  32'h0);
  endtask

  initial begin
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    if_load_done = 1'b0;
    mem_data     = 32'h0;
    jump_flag    = 1'b0;
    jump_addr    = 32'h0;
    inst_ready   = 1'b0;

    // ---- reset state
    step();
    step();
    chk_reset_outputs("rst0");

    // ---- fill queue with 1-cycle hits, decoder stalled
    rst_in  = 1'b1;
    mem_en  = 1'b1;
    mem_lat = 1;
    mem_cnt = 0;
    step();
    chk("fill_first_req",  {31'b0, if_read_or_not}, 32'h1);
    chk("fill_first_addr", intru_addr,               32'h0);
    chk("fill_not_valid",  {31'b0, inst_valid},     32'h0);
    step();
    step();
    chk("hit_latency_valid", {31'b0, inst_valid}, 32'h1);
    chk("hit_latency_pc",    inst_pc,              32'h0);
    chk("hit_latency_out",   inst_out,             32'h100);
    for (int i = 0; i < 60; i++) step();
    chk("full_no_req",   {31'b0, if_read_or_not}, 32'h0);
    chk("full_head_pc",  inst_pc,                  32'h0);
    chk("full_head_out", inst_out,                 32'h100);
    step();
    chk("full_still_no_req", {31'b0, if_read_or_not}, 32'h0);

    // ---- single pop from a full queue triggers exactly one refill at 0x40
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("pop_head_pc",  inst_pc,                  32'h4);
    chk("pop_head_out", inst_out,                 32'h104);
    chk("pop_no_req",   {31'b0, if_read_or_not}, 32'h0);
    step();
    chk("refill_req",  {31'b0, if_read_or_not}, 32'h1);
    chk("refill_addr", intru_addr,               32'h40);
    step();
    step();
    chk("refill_done_req", {31'b0, if_read_or_not}, 32'h0);
    step();
    chk("refull_no_req", {31'b0, if_read_or_not}, 32'h0);

    // ---- drain 15 entries; head wraps to the 0x40 entry in slot 0
    inst_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    inst_ready = 1'b0;
    chk("wrap_head_pc",  inst_pc,  32'h40);
    chk("wrap_head_out", inst_out, 32'h140);

    // ---- redirect coinciding with done for the fetch at 0x8
    mem_en       = 1'b0;
    if_load_done = 1'b0;
    rst_in       = 1'b0;
    step();
    rst_in  = 1'b1;
    mem_en  = 1'b1;
    mem_cnt = 0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_jump_req",   {31'b0, if_read_or_not}, 32'h1);
    chk("pre_jump_addr",  intru_addr,               32'h8);
    chk("pre_jump_valid", {31'b0, inst_valid},     32'h1);
    mem_en       = 1'b0;
    if_load_done = 1'b1;
    mem_data     = 32'h108;
    jump_flag    = 1'b1;
    jump_addr    = 32'h1000;
    step();
    jump_flag    = 1'b0;
    if_load_done = 1'b0;
    chk("jump_flush_valid", {31'b0, inst_valid},     32'h0);
    chk("jump_no_req",      {31'b0, if_read_or_not}, 32'h0);
    step();
    step();
    chk("jump_req",       {31'b0, if_read_or_not}, 32'h1);
    chk("jump_addr",      intru_addr,               32'h1000);
    chk("jump_still_empty", {31'b0, inst_valid},   32'h0);

    // ---- redirect to 0x2000 followed by a stale done
    jump_flag = 1'b1;
    jump_addr = 32'h2000;
    step();
    jump_flag    = 1'b0;
    if_load_done = 1'b1;
    mem_data     = 32'hDEAD;
    step();
    if_load_done = 1'b0;
    chk("stale_dropped", {31'b0, inst_valid}, 32'h0);
    step();
    chk("jump2_req",  {31'b0, if_read_or_not}, 32'h1);
    chk("jump2_addr", intru_addr,               32'h2000);
    mem_en  = 1'b1;
    mem_cnt = 0;
    step();
    step();
    step();
    chk("jump2_valid", {31'b0, inst_valid}, 32'h1);
    chk("jump2_pc",    inst_pc,              32'h2000);
    chk("jump2_out",   inst_out,             32'h2100);

    // ---- miss: done after 6 cycles of held request
    mem_lat = 6;
    step();
    chk("miss_req0",  {31'b0, if_read_or_not}, 32'h1);
    chk("miss_addr0", intru_addr,               32'h2004);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("miss_req_hold",  {31'b0, if_read_or_not}, 32'h1);
      chk("miss_addr_hold", intru_addr,               32'h2004);
    end
    step();
    chk("miss_done_req", {31'b0, if_read_or_not}, 32'h0);
    chk("miss_head_pc",  inst_pc,                  32'h2000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("miss_pop_pc",   inst_pc,    32'h2004);
    chk("miss_pop_out",  inst_out,   32'h2104);
    chk("miss_next_addr", intru_addr, 32'h2008);

    // ---- rdy_in low for 3 cycles mid-WAIT; a done in that window is lost
    mem_en = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_load_done = (i == 1);
      mem_data     = 32'hBAD;
      step();
      chk("frz_req",   {31'b0, if_read_or_not}, 32'h1);
      chk("frz_addr",  intru_addr,               32'h2008);
      chk("frz_valid", {31'b0, inst_valid},     32'h1);
      chk("frz_pc",    inst_pc,                  32'h2004);
      chk("frz_out",   inst_out,                 32'h2104);
    end
    if_load_done = 1'b0;
    rdy_in       = 1'b1;
    step();
    chk("unfrz_req",  {31'b0, if_read_or_not}, 32'h1);
    chk("unfrz_addr", intru_addr,               32'h2008);
    if_load_done = 1'b1;
    mem_data     = 32'h2108;
    step();
    if_load_done = 1'b0;
    chk("unfrz_done_req", {31'b0, if_read_or_not}, 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("unfrz_pop_pc",  inst_pc,    32'h2008);
    chk("unfrz_pop_out", inst_out,   32'h2108);
    chk("unfrz_next",    intru_addr, 32'h200C);

    // ---- build 5 entries, then reset while a fetch is outstanding
    for (int i = 0; i < 4; i++) begin
      if_load_done = 1'b1;
      mem_data     = intru_addr + 32'h100;
      step();
      if_load_done = 1'b0;
      step();
    end
    chk("pre_rst_req",   {31'b0, if_read_or_not}, 32'h1);
    chk("pre_rst_addr",  intru_addr,               32'h201C);
    chk("pre_rst_valid", {31'b0, inst_valid},     32'h1);
    chk("pre_rst_pc",    inst_pc,                  32'h2008);
    rst_in = 1'b0;
    step();
    chk_reset_outputs("rst1");
    rst_in       = 1'b1;
    if_load_done = 1'b1;
    mem_data     = 32'h777;
    step();
    if_load_done = 1'b0;
    chk("post_rst_req",   {31'b0, if_read_or_not}, 32'h1);
    chk("post_rst_addr",  intru_addr,               32'h0);
    chk("post_rst_valid", {31'b0, inst_valid},     32'h0);
    step();
    chk("post_rst_empty", {31'b0, inst_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the memory controller's instruction port.
- Holds the PC and issues one 4-byte fetch request at a time to the memory controller, then waits for its done pulse.
- Pushes each returned instruction, tagged with its PC, into a circular instruction queue that the decoder drains.
- A branch/jump redirect flushes the queue and restarts fetch at the new PC.

Parameters:
IQ_DEPTH, 16, number of queue entries (power of two)
IQ_ADDR_LEN, 4, log2(IQ_DEPTH); width of the head/tail pointers
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_in  input  1  synchronous reset, active-low (0 = reset)
rdy_in  input  1  global enable; when 0, all state and outputs freeze
if_read_or_not  output  1  fetch request to the memory controller
intru_addr  output  32  fetch address; stable while if_read_or_not=1 unless a redirect occurs
if_load_done  input  1  one-cycle pulse from the memory controller; instruction valid
mem_ctrl_instru_to_if  input  32  fetched instruction word, valid with if_load_done
jump_flag  input  1  redirect request from the commit/branch stage
jump_addr  input  32  redirect target PC
inst_valid  output  1  queue not empty
inst_out  output  32  instruction at the queue head
inst_pc  output  32  PC of the queue-head instruction
inst_ready  input  1  decoder pops the head this cycle when inst_valid=1

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - pc=RESET_PC; head=tail=count=0; state=IDLE.
  - Outputs: if_read_or_not=0, intru_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0.
  - Reset mid-fetch abandons the request; any done pulse in the following cycle is ignored (reset enters IDLE, and DROP semantics apply for one cycle).
- rdy_in=0: no register changes; a done pulse arriving in that cycle is lost. This is acceptable only because the memory controller is frozen by the same rdy_in.
- States:
  - IDLE: if count < IQ_DEPTH, then if_read_or_not<=1, intru_addr<=pc, and go to WAIT. The condition guarantees room for the outstanding word.
  - WAIT: hold if_read_or_not=1 and intru_addr constant. On if_load_done=1: write {pc, mem_ctrl_instru_to_if} at tail; tail<=tail+1 (wraps mod IQ_DEPTH); pc<=pc+4 (32-bit wrap); if_read_or_not<=0; go to IDLE. Minimum gap between requests is one cycle.
  - DROP: entered for exactly one cycle after a redirect. Any if_load_done in this cycle is discarded, since it belongs to the pre-redirect address. Then go to IDLE.
- Redirect (jump_flag=1), highest priority, from any state:
  - pc<=jump_addr; head<=tail<=count<=0; if_read_or_not<=0; state<=DROP.
  - A simultaneous done or pop is ignored.
  - inst_valid drops to 0 on the next cycle.
- Queue:
  - inst_valid = (count!=0); inst_out/inst_pc read the head entry directly from registers.
  - Pop when inst_valid & inst_ready: head<=head+1 (wraps).
  - Push and pop in the same cycle leave count unchanged.
  - inst_ready while empty has no effect.
  - Push cannot overflow, because a request is issued only when count < IQ_DEPTH.
- Counter widths: count is IQ_ADDR_LEN+1 bits; full is count==IQ_DEPTH.
- Latency:
  - Cache hit: request at cycle N, done at N+1, inst_valid at N+2.
  - Miss: done follows after the memory controller's 6-cycle byte sequence.

Test Plan:
- Reset release with RESET_PC=0; memory controller model returns word=addr+0x100 with 1-cycle latency; inst_ready=0 → queue fills with 16 entries at PCs 0x0..0x3C, if_read_or_not stays 0 while full, inst_pc=0x0 and inst_out=0x100 at head.
- Full queue; pulse inst_ready for 1 cycle → head advances to PC 0x4; exactly one new fetch at 0x40 is issued and pushed; count returns to 16.
- Fetch outstanding at 0x8; jump_flag=1 with jump_addr=0x1000 in the same cycle as if_load_done → done discarded, queue empty next cycle, next request has intru_addr=0x1000.
- Redirect to 0x2000, then a stale done pulse in the following cycle → pulse dropped, first queued entry has inst_pc=0x2000.
- Miss latency: done arrives 6 cycles after the request → intru_addr held constant all 6 cycles, one push, pc advances by 4.
- rdy_in=0 for 3 cycles mid-WAIT → all outputs unchanged; fetch completes normally after rdy_in returns to 1.
- rst_in=0 while in WAIT with 5 entries queued → next cycle all outputs at reset values, count=0.
